// File: rtl/sa_mm_sequencer_pkg.sv
// Shared types and helpers for the systolic matrix-multiply sequencer.
// State encoding, flat element indexing and the feed-cycle count.
package sa_mm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Flat index of element (r,c) in a row-major NxN matrix.
    function automatic int sa_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

    // Cycles needed to push every skewed operand into an NxN array.
    function automatic int feed_cycles(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/sa_mm_sequencer_skew_feeder.sv
// Picks the N skewed operands for feed cycle k from a latched NxN matrix.
// COL=0 walks rows (A operand), COL=1 walks columns (B operand).
module sa_mm_sequencer_skew_feeder
    import sa_mm_sequencer_pkg::*;
#(
    parameter int W   = 16,
    parameter int N   = 3,
    parameter int COL = 0,
    parameter int KW  = 4
) (
    input  logic [W*N*N-1:0] mat,
    input  logic [KW-1:0]    k,
    output logic [W*N-1:0]   feed
);

    // Lane i carries element j where i + j == k; lanes outside the wavefront stay zero.
    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        feed = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (int'(k) == i + j) begin
                    feed[W*i +: W] = (COL != 0) ? mat[W*sa_idx(j, i, N) +: W]
                                                : mat[W*sa_idx(i, j, N) +: W];
                end
            end
        end
    end

endmodule

// File: rtl/sa_mm_sequencer.sv
// Control path for an external output-stationary NxN PE array: accepts an A/B job,
// streams skewed operands, drains the MAC pipeline and returns the captured C.
module sa_mm_sequencer
    import sa_mm_sequencer_pkg::*;
#(
    parameter int W      = 16,
    parameter int N      = 3,
    parameter int PE_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_mode,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic [W*N-1:0]   o_a_feed,
    output logic [W*N-1:0]   o_b_feed,
    output logic             o_pe_en,
    output logic             o_pe_clear,
    input  logic [W*N*N-1:0] i_pe_c,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W*N*N-1:0] o_C,
    output logic             o_busy
);

    localparam int KW = $clog2(3 * N);
    localparam int DW = $clog2(PE_LAT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(feed_cycles(N) - 1);
    localparam logic [DW-1:0] D_LAST = DW'(PE_LAT - 1);

    state_t             state, state_next;
    logic [KW-1:0]      k, k_sel;
    logic [DW-1:0]      drain_cnt;
    logic [W*N*N-1:0]   a_mat, b_mat, c_q;
    logic               mode_q;
    logic [W*N-1:0]     a_feed, b_feed, a_next, b_next;
    logic               feed_done, drain_done;

    assign feed_done  = (k == K_LAST);
    assign drain_done = (drain_cnt == D_LAST);
    // Feeds are registered, so the feeder looks one step ahead of k.
    assign k_sel      = (state == ST_FEED) ? k + 1'b1 : '0;

    sa_mm_sequencer_skew_feeder #(.W(W), .N(N), .COL(0), .KW(KW)) u_feed_a (
        .mat  (a_mat),
        .k    (k_sel),
        .feed (a_next)
    );

    sa_mm_sequencer_skew_feeder #(.W(W), .N(N), .COL(1), .KW(KW)) u_feed_b (
        .mat  (b_mat),
        .k    (k_sel),
        .feed (b_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_valid) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_FEED;
            ST_FEED:  if (i_en && feed_done) state_next = ST_DRAIN;
            ST_DRAIN: if (i_en && drain_done) state_next = ST_OUT;
            ST_OUT:   if (i_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Datapath registers; a reset mid-job drops everything so no partial result escapes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            a_mat     <= '0;
            b_mat     <= '0;
            mode_q    <= 1'b0;
            k         <= '0;
            drain_cnt <= '0;
            a_feed    <= '0;
            b_feed    <= '0;
            c_q       <= '0;
        end else begin
            if (state == ST_IDLE && i_valid) begin
                a_mat  <= i_A;
                b_mat  <= i_B;
                mode_q <= i_mode;
            end
            if (state == ST_CLEAR) begin
                k         <= '0;
                drain_cnt <= '0;
                a_feed    <= a_next;
                b_feed    <= b_next;
            end
            if (state == ST_FEED && i_en) begin
                if (feed_done) begin
                    a_feed <= '0;
                    b_feed <= '0;
                end else begin
                    k      <= k + 1'b1;
                    a_feed <= a_next;
                    b_feed <= b_next;
                end
            end
            if (state == ST_DRAIN && i_en) begin
                if (drain_done) c_q <= i_pe_c;
                else            drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

    assign o_ready    = (state == ST_IDLE);
    assign o_busy     = (state != ST_IDLE);
    assign o_valid    = (state == ST_OUT);
    assign o_pe_en    = i_en && (state == ST_FEED || state == ST_DRAIN);
    assign o_pe_clear = (state == ST_CLEAR) && !mode_q;
    assign o_a_feed   = a_feed;
    assign o_b_feed   = b_feed;
    assign o_C        = c_q;

endmodule

// File: tb/tb_sa_mm_sequencer.sv
// Scoreboarded bench for sa_mm_sequencer driving a behavioural 3x3 integer-MAC PE array.
module tb_sa_mm_sequencer;

    localparam int W      = 16;
    localparam int N      = 3;
    localparam int PE_LAT = 1;
    localparam int MW     = W * N * N;
    localparam int VW     = W * N;

    typedef logic [MW-1:0] mat_t;
    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic job_valid = 1'b0;
    logic job_mode = 1'b0;
    logic c_ready = 1'b1;
    mat_t in_a = '0;
    mat_t in_b = '0;
    logic ready, pe_en, pe_clear, c_valid, busy;
    vec_t a_feed, b_feed;
    mat_t pe_c, c_out;

    int passed = 0;
    int total  = 0;
    mat_t exp_q[$];

    always #5 clk = ~clk;

    sa_mm_sequencer #(.W(W), .N(N), .PE_LAT(PE_LAT)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_valid    (job_valid),
        .o_ready    (ready),
        .i_mode     (job_mode),
        .i_A        (in_a),
        .i_B        (in_b),
        .o_a_feed   (a_feed),
        .o_b_feed   (b_feed),
        .o_pe_en    (pe_en),
        .o_pe_clear (pe_clear),
        .i_pe_c     (pe_c),
        .o_valid    (c_valid),
        .i_ready    (c_ready),
        .o_C        (c_out),
        .o_busy     (busy)
    );

    // Output-stationary PE grid: A flows right, B flows down, each PE accumulates a*b.
    logic [W-1:0] a_reg [N][N];
    logic [W-1:0] b_reg [N][N];
    logic [W-1:0] acc   [N][N];

    function automatic logic [W-1:0] a_in(input int r, input int c);
        return (c == 0) ? a_feed[W*r +: W] : a_reg[r][c-1];
    endfunction

    function automatic logic [W-1:0] b_in(input int r, input int c);
        return (r == 0) ? b_feed[W*c +: W] : b_reg[r-1][c];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end
        end else if (pe_clear) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) acc[r][c] <= '0;
        end else if (pe_en) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    acc[r][c]   <= acc[r][c] + W'(a_in(r, c) * b_in(r, c));
                    a_reg[r][c] <= a_in(r, c);
                    b_reg[r][c] <= b_in(r, c);
                end
        end
    end

    always_comb begin
        pe_c = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) pe_c[W*(r*N+c) +: W] = acc[r][c];
    end

    task automatic check(input string name, input mat_t act, input mat_t exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic mat_t mk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int v [9];
        mat_t m;
        v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        m = '0;
        for (int i = 0; i < 9; i++) m[W*i +: W] = W'(v[i]);
        return m;
    endfunction

    // Monitor: every result handshake pops the oldest expected C.
    always @(negedge clk) begin
        if (rst_n && c_valid && c_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got %h, want no result", c_out);
            end else begin
                check("o_C", c_out, exp_q.pop_front());
            end
        end
    end

    // Issue one job and follow it cycle by cycle; optional stall, back-pressure or reset.
    task automatic run_job(input string tag, input mat_t a, input mat_t b, input logic m,
                           input mat_t expc, input int lat_exp, input int stall_at,
                           input int bp, input int rst_at, input bit skew);
        int n;
        int stray;
        bit seen;
        check({tag, " o_ready idle"}, MW'(ready), MW'(1));
        in_a = a; in_b = b; job_mode = m; job_valid = 1'b1;
        c_ready = (bp == 0);
        if (rst_at == 0) exp_q.push_back(expc);
        @(posedge clk); #1;
        job_valid = 1'b0;
        check({tag, " o_pe_clear"}, MW'(pe_clear), MW'(!m));
        n = 0; stray = 0; seen = 1'b0;
        while (n < 60 && !seen) begin
            @(posedge clk); #1;
            n++;
            if (pe_clear) stray++;
            if (skew && n == 3) begin
                check({tag, " a_feed k2"}, MW'(a_feed), MW'({16'd7, 16'd5, 16'd3}));
                check({tag, " b_feed k2"}, MW'(b_feed), MW'({16'd1, 16'd1, 16'd1}));
                check({tag, " pe_en k2"}, MW'(pe_en), MW'(1));
            end
            if (skew && n == 8) begin
                check({tag, " drain feeds"}, MW'({a_feed, b_feed}), MW'(0));
                check({tag, " drain busy"}, MW'(busy), MW'(1));
            end
            if (stall_at > 0 && n >= stall_at && n <= stall_at + 4) begin
                check({tag, " frozen a_feed"}, MW'(a_feed), MW'({16'd8, 16'd6, 16'd0}));
                check({tag, " frozen b_feed"}, MW'(b_feed), MW'({16'd1, 16'd1, 16'd0}));
                if (n > stall_at) check({tag, " pe_en stalled"}, MW'(pe_en), MW'(0));
                if (n == stall_at)     en = 1'b0;
                if (n == stall_at + 4) en = 1'b1;
            end
            if (rst_at > 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " reset ctl"}, MW'({ready, c_valid, busy, pe_en}), MW'(4'b1000));
                check({tag, " reset feeds"}, MW'({a_feed, b_feed}), MW'(0));
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                check({tag, " no result"}, MW'(c_valid), MW'(0));
                return;
            end
            seen = c_valid;
        end
        check({tag, " latency"}, MW'(n), MW'(lat_exp));
        if (!seen) return;
        if (bp > 0) begin
            job_valid = 1'b1;
            in_a = mk(9, 9, 9, 9, 9, 9, 9, 9, 9);
            for (int i = 0; i < bp; i++) begin
                check({tag, " bp hold"}, MW'({c_valid, ready}), MW'(2'b10));
                check({tag, " bp o_C"}, c_out, expc);
                if (i < bp - 1) begin @(posedge clk); #1; end
            end
            c_ready = 1'b1;
            job_valid = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, " after handshake"}, MW'({c_valid, ready}), MW'(2'b01));
        @(posedge clk); #1;
        check({tag, " idle after"}, MW'(busy), MW'(0));
        check({tag, " stray clear"}, MW'(stray), MW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        mat_t a, eye, ones, a2, row_sum;
        a       = mk(1, 2, 3, 4, 5, 6, 7, 8, 9);
        eye     = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
        ones    = mk(1, 1, 1, 1, 1, 1, 1, 1, 1);
        a2      = mk(2, 4, 6, 8, 10, 12, 14, 16, 18);
        row_sum = mk(6, 6, 6, 15, 15, 15, 24, 24, 24);

        #1;
        check("reset ctl", MW'({ready, c_valid, pe_en, pe_clear, busy}), MW'(5'b10000));
        check("reset feeds", MW'({a_feed, b_feed}), MW'(0));
        check("reset o_C", c_out, '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job("identity",   a, eye,  1'b0, a,       9,  0, 0, 0, 1'b0);
        run_job("accumulate", a, eye,  1'b1, a2,      9,  0, 0, 0, 1'b0);
        run_job("skew",       a, ones, 1'b0, row_sum, 9,  0, 0, 0, 1'b1);
        run_job("stall",      a, ones, 1'b0, row_sum, 13, 4, 0, 0, 1'b0);
        run_job("backpress",  a, ones, 1'b0, row_sum, 9,  0, 5, 0, 1'b0);
        run_job("reset_mid",  a, ones, 1'b0, row_sum, 0,  0, 0, 5, 1'b0);
        run_job("after_rst",  a, eye,  1'b0, a,       9,  0, 0, 0, 1'b0);

        check("scoreboard drained", MW'(exp_q.size()), MW'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
